// File: rtl/auto_intf.sv
// Credit-based request/response channel: buffers tagged 64-bit requests in a FIFO and issues
// one registered response per request as response credits allow, with error reports for drops.
module auto_intf #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned RSP_CREDITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_val,
    input  logic [63:0] req_dat,
    input  logic        manually_listed,
    output logic        req_credit,
    output logic [1:0]  rsp_cmd,
    output logic [63:0] rsp_data,
    input  logic        rsp_credit,
    input  logic        in_pure,
    output logic        out_pure
);

    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned CredW = $clog2(RSP_CREDITS + 1);

    localparam logic [CntW-1:0]  CntFull = CntW'(DEPTH);
    localparam logic [CredW-1:0] CredMax = CredW'(RSP_CREDITS);

    typedef enum logic [1:0] {
        CmdIdle = 2'b00,
        CmdData = 2'b01,
        CmdErr  = 2'b10,
        CmdTag  = 2'b11
    } cmd_e;

    logic [64:0]      mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CredW-1:0] cred_q, cred_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             err_pend_q, err_pend_d;
    cmd_e             rsp_cmd_q, rsp_cmd_d;
    logic [63:0]      rsp_data_q, rsp_data_d;
    logic             req_credit_q, req_credit_d;
    logic             out_pure_q;

    logic        full, push, drop, has_cred, issue_err, issue_dat, issue;
    logic [64:0] head;

    always_comb begin
        full      = (cnt_q == CntFull);
        push      = req_val & ~full;
        drop      = req_val & full;
        has_cred  = (cred_q != '0);
        issue_err = has_cred & err_pend_q;
        issue_dat = has_cred & ~err_pend_q & (cnt_q != '0);
        issue     = issue_err | issue_dat;
        head      = mem_q[rd_ptr_q];

        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = issue_dat ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

        cnt_d = cnt_q;
        if (push && !issue_dat) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!push && issue_dat) begin
            cnt_d = cnt_q - CntW'(1);
        end

        // A drop in the same cycle as an error report starts the next report at one.
        drop_cnt_d = drop_cnt_q;
        err_pend_d = err_pend_q;
        if (issue_err) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
            err_pend_d = drop;
        end else if (drop) begin
            err_pend_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end

        cred_d = cred_q;
        if (issue && !rsp_credit) begin
            cred_d = cred_q - CredW'(1);
        end else if (!issue && rsp_credit && cred_q != CredMax) begin
            cred_d = cred_q + CredW'(1);
        end

        rsp_cmd_d    = CmdIdle;
        rsp_data_d   = '0;
        req_credit_d = 1'b0;
        if (issue_err) begin
            rsp_cmd_d  = CmdErr;
            rsp_data_d = {48'b0, drop_cnt_q};
        end else if (issue_dat) begin
            rsp_cmd_d    = head[64] ? CmdTag : CmdData;
            rsp_data_d   = head[63:0];
            req_credit_d = 1'b1;
        end
    end

    // Storage needs no reset; the occupancy counter defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {manually_listed, req_dat};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            cred_q       <= CredMax;
            drop_cnt_q   <= '0;
            err_pend_q   <= 1'b0;
            rsp_cmd_q    <= CmdIdle;
            rsp_data_q   <= '0;
            req_credit_q <= 1'b0;
            out_pure_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            cred_q       <= cred_d;
            drop_cnt_q   <= drop_cnt_d;
            err_pend_q   <= err_pend_d;
            rsp_cmd_q    <= rsp_cmd_d;
            rsp_data_q   <= rsp_data_d;
            req_credit_q <= req_credit_d;
            out_pure_q   <= in_pure;
        end
    end

    assign rsp_cmd    = rsp_cmd_q;
    assign rsp_data   = rsp_data_q;
    assign req_credit = req_credit_q;
    assign out_pure   = out_pure_q;

endmodule

// File: tb/tb_auto_intf.sv
// Bench for auto_intf: directed scenarios plus randomized traffic against a queue-based model.
module tb_auto_intf;

    localparam int DEPTH       = 4;
    localparam int RSP_CREDITS = 2;

    logic        clk;
    logic        rst_n;
    logic        req_val;
    logic [63:0] req_dat;
    logic        manually_listed;
    logic        req_credit;
    logic [1:0]  rsp_cmd;
    logic [63:0] rsp_data;
    logic        rsp_credit;
    logic        in_pure;
    logic        out_pure;

    int n_cmp  = 0;
    int n_fail = 0;

    auto_intf #(
        .DEPTH      (DEPTH),
        .RSP_CREDITS(RSP_CREDITS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_val        (req_val),
        .req_dat        (req_dat),
        .manually_listed(manually_listed),
        .req_credit     (req_credit),
        .rsp_cmd        (rsp_cmd),
        .rsp_data       (rsp_data),
        .rsp_credit     (rsp_credit),
        .in_pure        (in_pure),
        .out_pure       (out_pure)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of {tag, payload}, a pending-error flag, a drop count and a
    // credit count, advanced once per clock edge from the inputs about to be sampled.
    logic [64:0] m_q[$];
    bit          m_err;
    int          m_drop;
    int          m_cred;
    logic [1:0]  e_cmd;
    logic [63:0] e_data;
    logic        e_crd;
    logic        e_pure;

    task automatic model_reset();
        m_q.delete();
        m_err  = 1'b0;
        m_drop = 0;
        m_cred = RSP_CREDITS;
        e_cmd  = 2'd0;
        e_data = 64'd0;
        e_crd  = 1'b0;
        e_pure = 1'b0;
    endtask

    task automatic model_edge();
        bit          was_full;
        int          issued;
        logic [64:0] h;
        was_full = (m_q.size() == DEPTH);
        issued   = 0;
        e_cmd    = 2'd0;
        e_data   = 64'd0;
        e_crd    = 1'b0;
        if (m_cred > 0 && m_err) begin
            e_cmd  = 2'd2;
            e_data = 64'(m_drop);
            m_err  = 1'b0;
            m_drop = 0;
            issued = 1;
        end else if (m_cred > 0 && m_q.size() > 0) begin
            h      = m_q.pop_front();
            e_cmd  = h[64] ? 2'd3 : 2'd1;
            e_data = h[63:0];
            e_crd  = 1'b1;
            issued = 1;
        end
        if (req_val) begin
            if (was_full) begin
                if (m_drop < 65535) m_drop++;
                m_err = 1'b1;
            end else begin
                m_q.push_back({manually_listed, req_dat});
            end
        end
        m_cred = m_cred - issued + (rsp_credit ? 1 : 0);
        if (m_cred > RSP_CREDITS) m_cred = RSP_CREDITS;
        e_pure = in_pure;
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs settled.
    task automatic step(input logic v, input logic [63:0] d, input logic t, input logic c);
        req_val         = v;
        req_dat         = d;
        manually_listed = t;
        rsp_credit      = c;
        in_pure         = 1'($urandom);
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_val = 1'b0; req_dat = '0; manually_listed = 1'b0; rsp_credit = 1'b0; in_pure = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_val = 1'b0; req_dat = '0; manually_listed = 1'b0; rsp_credit = 1'b0; in_pure = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if ({rsp_cmd, rsp_data, req_credit, out_pure} !== 68'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {rsp_cmd, rsp_data, req_credit, out_pure});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 64'd0, 1'b0, 1'b0);
            n_cmp++;
            if ({rsp_cmd, rsp_data, req_credit} !== 67'd0 || out_pure !== e_pure) begin
                n_fail++;
                $display("FAIL reset_idle: got cmd=%0d data=%h crd=%b pure=%b want 0/0/0/%b",
                         rsp_cmd, rsp_data, req_credit, out_pure, e_pure);
            end
        end
    endtask

    task automatic test_single();
        logic [1:0]  want_cmd [3] = '{2'd0, 2'd1, 2'd0};
        logic [63:0] want_dat [3] = '{64'd0, 64'hDEAD_BEEF_0000_0001, 64'd0};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step(i == 0, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
            n_cmp++;
            if (rsp_cmd !== want_cmd[i] || rsp_data !== want_dat[i] ||
                req_credit !== (i == 1) || out_pure !== e_pure) begin
                n_fail++;
                $display("FAIL single[%0d]: got cmd=%0d data=%h crd=%b want cmd=%0d data=%h",
                         i, rsp_cmd, rsp_data, req_credit, want_cmd[i], want_dat[i]);
            end
        end
    endtask

    task automatic test_credit_stall();
        logic [63:0] a, b, c;
        logic [63:0] want_dat [8];
        logic [1:0]  want_cmd [8];
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        c = {$urandom, $urandom};
        want_dat = '{64'd0, a, b, 64'd0, 64'd0, 64'd0, c, 64'd0};
        want_cmd = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            step(i < 3, (i == 0) ? a : (i == 1) ? b : c, 1'b0, i == 5);
            n_cmp++;
            if (rsp_cmd !== want_cmd[i] || rsp_data !== want_dat[i] ||
                req_credit !== want_cmd[i][0]) begin
                n_fail++;
                $display("FAIL credit_stall[%0d]: got cmd=%0d data=%h crd=%b want cmd=%0d data=%h",
                         i, rsp_cmd, rsp_data, req_credit, want_cmd[i], want_dat[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [63:0] d [6];
        apply_reset();
        for (int i = 0; i < 6; i++) d[i] = {32'hA5A5_0000, 32'(i)};
        step(1'b1, 64'hF0, 1'b0, 1'b0);
        step(1'b1, 64'hF1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, d[i], 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b0);
        n_cmp++;
        if (rsp_cmd !== 2'd0) begin
            n_fail++;
            $display("FAIL overflow_stalled: got cmd=%0d want 0", rsp_cmd);
        end
        step(1'b0, 64'd0, 1'b0, 1'b1);
        step(1'b0, 64'd0, 1'b0, 1'b0);
        n_cmp++;
        if (rsp_cmd !== 2'd2 || rsp_data !== 64'd2 || req_credit !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_err: got cmd=%0d data=%h crd=%b want cmd=2 data=2 crd=0",
                     rsp_cmd, rsp_data, req_credit);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 64'd0, 1'b0, 1'b1);
            step(1'b0, 64'd0, 1'b0, 1'b0);
            n_cmp++;
            if (rsp_cmd !== 2'd1 || rsp_data !== d[i] || req_credit !== 1'b1) begin
                n_fail++;
                $display("FAIL overflow_drain[%0d]: got cmd=%0d data=%h crd=%b want cmd=1 data=%h",
                         i, rsp_cmd, rsp_data, req_credit, d[i]);
            end
        end
    endtask

    task automatic test_tagged();
        apply_reset();
        step(1'b1, 64'h5, 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b0);
        n_cmp++;
        if (rsp_cmd !== 2'd3 || rsp_data !== 64'h5 || req_credit !== 1'b1) begin
            n_fail++;
            $display("FAIL tagged: got cmd=%0d data=%h crd=%b want cmd=3 data=5 crd=1",
                     rsp_cmd, rsp_data, req_credit);
        end
    endtask

    task automatic test_credit_saturation();
        int seen;
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 64'd0, 1'b0, 1'b1);
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            step(i < 3, 64'(100 + i), 1'b0, 1'b0);
            if (rsp_cmd != 2'd0) seen++;
        end
        n_cmp++;
        if (seen !== 2) begin
            n_fail++;
            $display("FAIL credit_sat_count: got %0d responses want 2", seen);
        end
        step(1'b0, 64'd0, 1'b0, 1'b1);
        step(1'b0, 64'd0, 1'b0, 1'b0);
        n_cmp++;
        if (rsp_cmd !== 2'd1 || rsp_data !== 64'd102) begin
            n_fail++;
            $display("FAIL credit_sat_third: got cmd=%0d data=%h want cmd=1 data=66",
                     rsp_cmd, rsp_data);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 64'(200 + i), 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b1);
        step(1'b0, 64'd0, 1'b0, 1'b0);
        n_cmp++;
        if (rsp_cmd !== 2'd1 || rsp_data !== 64'd202) begin
            n_fail++;
            $display("FAIL mid_pre: got cmd=%0d data=%h want cmd=1 data=ca", rsp_cmd, rsp_data);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({rsp_cmd, rsp_data, req_credit, out_pure} !== 68'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h want 0", {rsp_cmd, rsp_data, req_credit, out_pure});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 64'd0, 1'b0, 1'b1);
            n_cmp++;
            if (rsp_cmd !== 2'd0 || rsp_data !== 64'd0 || req_credit !== 1'b0 ||
                out_pure !== e_pure) begin
                n_fail++;
                $display("FAIL mid_stale[%0d]: got cmd=%0d data=%h crd=%b pure=%b want 0/0/0/%b",
                         i, rsp_cmd, rsp_data, req_credit, out_pure, e_pure);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 3) != 0, {$urandom, $urandom}, 1'($urandom),
                 ($urandom % 3) == 0);
            n_cmp++;
            if (rsp_cmd !== e_cmd || rsp_data !== e_data || req_credit !== e_crd ||
                out_pure !== e_pure) begin
                n_fail++;
                $display("FAIL random[%0d]: got cmd=%0d data=%h crd=%b pure=%b want %0d/%h/%b/%b",
                         i, rsp_cmd, rsp_data, req_credit, out_pure, e_cmd, e_data, e_crd, e_pure);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        req_val = 1'b0; req_dat = '0; manually_listed = 1'b0; rsp_credit = 1'b0; in_pure = 1'b0;
        model_reset();
        #3;
        test_reset();
        test_single();
        test_credit_stall();
        test_overflow();
        test_tagged();
        test_credit_saturation();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/auto_intf.md
# auto_intf

Credit-based request/response channel block. Accepts 64-bit requests from a requester that holds DEPTH credits, buffers them in a FIFO, and issues one response per request toward a consumer that grants response credits. Returns one request credit per drained entry, and reports dropped (overflowed) requests with an error response. Carries a one-bit registered pass-through (in_pure to out_pure). Sits between a request monitor port and a response driver port.

## Interface
- DEPTH, 4, request FIFO entries; also the requester's initial credit count (power of two, at least 2)
- RSP_CREDITS, 2, initial and maximum response-credit count (at least 1)
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_val  in  1  request valid; one request per cycle while high.
- req_dat  in  64  request payload, sampled when req_val=1.
- manually_listed  in  1  tag bit, sampled with req_val; marks the request as tagged.
- req_credit  out  1  one-cycle pulse; returns one request credit.
- rsp_cmd  out  2  response command: 00 idle, 01 data, 10 error, 11 tagged data.
- rsp_data  out  64  response payload.
- rsp_credit  in  1  one-cycle pulse; grants one response credit.
- in_pure  in  1  side-band input.
- out_pure  out  1  in_pure registered one cycle.

## Operation
- FIFO entry: {tag, payload}, 65 bits. Read and write pointers wrap modulo DEPTH. Occupancy counter runs 0..DEPTH.
- Push:
  - When req_val=1 and occupancy<DEPTH, {manually_listed, req_dat} is written at the clock edge.
  - Fullness is evaluated before any same-cycle pop. A request that arrives while full is dropped, even if a pop happens in that cycle.
- Drop handling:
  - A dropped request increments drop_cnt (16 bits, saturates at 0xFFFF) and sets err_pend.
- Response credits:
  - cred_cnt resets to RSP_CREDITS.
  - rsp_credit=1 increments it, but it never exceeds RSP_CREDITS; extra grants are ignored.
- Issue decision, made each cycle from registered state only:
  - If cred_cnt>0 and err_pend=1, issue an error response:
    - rsp_cmd=10, rsp_data={48'b0, drop_cnt}.
    - Clear err_pend and drop_cnt.
    - No FIFO pop and no req_credit.
    - If a drop occurs in the same cycle, err_pend stays set and drop_cnt becomes 1.
  - Otherwise, if cred_cnt>0 and the FIFO is not empty, pop the head entry:
    - rsp_cmd=11 if the tag is set, else 01.
    - rsp_data=payload.
    - req_credit=1.
  - Otherwise: rsp_cmd=00, rsp_data=0, req_credit=0.
- Error responses have priority over data responses.
- Every issued response (error or data) decrements cred_cnt. A same-cycle rsp_credit cancels the decrement (net zero).
- A grant arriving while cred_cnt=0 cannot be used in that same cycle.
- Responses are delivered in request order, at most one per cycle.
- out_pure <= in_pure every cycle.

## Timing
- Reset values:
  - Outputs: rsp_cmd=00, rsp_data=0, req_credit=0, out_pure=0.
  - Internal state: FIFO empty, pointers 0, cred_cnt=RSP_CREDITS, drop_cnt=0, err_pend=0.
  - Reset asserted mid-operation discards FIFO contents and pending errors immediately.
- rsp_cmd, rsp_data and req_credit are registered. Each response is valid for exactly one cycle, then returns to idle unless another response follows back-to-back.
- Latency: a request sampled at edge k into an empty FIFO, with credit available, appears on rsp_cmd/rsp_data after edge k+1. req_credit pulses in that same cycle.
- Throughput: one response per cycle while credits and data remain.
- out_pure latency is one cycle.

## Test plan
- Single request: reset, then req_val=1, req_dat=64'hDEAD_BEEF_0000_0001, manually_listed=0 for one cycle -> two edges later, one cycle of rsp_cmd=01, rsp_data=64'hDEAD_BEEF_0000_0001, req_credit=1; then rsp_cmd=00, rsp_data=0.
- Credit stall: send 3 back-to-back requests A, B, C with no rsp_credit -> A and B issue on consecutive cycles, then rsp_cmd stays 00. Pulse rsp_credit once -> C issues the next cycle with req_credit=1.
- Overflow: withhold rsp_credit with cred_cnt=0, send 6 requests -> 4 are stored and 2 are dropped. Grant one credit -> rsp_cmd=10, rsp_data=2 is issued before any data. Further grants drain the 4 entries in order.
- Tagged request: req_val=1 with manually_listed=1 and req_dat=64'h5 -> rsp_cmd=11, rsp_data=64'h5.
- Credit saturation: pulse rsp_credit 5 times with the FIFO empty (RSP_CREDITS=2), then send 3 requests -> only 2 responses issue until a new grant arrives.
- Reset mid-stream with 3 entries queued -> outputs go to 00/0 immediately. After reset release, no stale responses ever appear. out_pure follows in_pure with one-cycle delay throughout.
